// File: rtl/elevator_pkg.sv
// Shared types for the elevator scheduler: FSM states, travel direction
// and the default building size.
package elevator_pkg;

    localparam int NUM_FLOORS_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/call_register.sv
// Latched per-floor calls plus the demand reductions the scheduler steers by.
// Reductions are taken relative to eval_floor, which may be the floor the car is just reaching.
module call_register
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  serve,
    input  logic [FLOOR_W-1:0]    eval_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  here,
    output logic                  above,
    output logic                  below
);

    logic [NUM_FLOORS-1:0] served_mask;

    always_comb begin
        served_mask = '0;
        if (serve) served_mask[eval_floor] = 1'b1;
    end

    // Clearing the served floor wins over a simultaneous new call for it.
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= (pending | call_req) & ~served_mask;
    end

    always_comb begin
        here  = pending[eval_floor];
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i > int'(eval_floor))) above = 1'b1;
            if (pending[i] && (i < int'(eval_floor))) below = 1'b1;
        end
    end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN elevator controller: keeps travelling while calls lie ahead, times
// floor-to-floor travel and door dwell, and tracks the car floor.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = NUM_FLOORS_DEFAULT,
    parameter int FLOOR_W     = $clog2(NUM_FLOORS),
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    floor,
    output logic                  door_open,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  idle
);

    localparam int MCNT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
    localparam int DCNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MOVE_CYCLES - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DOOR_CYCLES - 1);

    state_t              state;
    dir_t                dir;
    logic [MCNT_W-1:0]   mcnt;
    logic [DCNT_W-1:0]   dcnt;
    logic                step;
    logic                serve;
    logic                here;
    logic                above;
    logic                below;
    logic [FLOOR_W-1:0]  eval_floor;

    // On the arrival cycle every decision is made against the floor being entered.
    always_comb begin
        step       = ((state == MOVE_UP) || (state == MOVE_DOWN)) && (mcnt == MCNT_LAST);
        eval_floor = floor;
        if (step) eval_floor = (state == MOVE_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
        serve      = (state == DOOR_OPEN) || (((state == IDLE) || step) && here);
    end

    call_register #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_calls (
        .clk        (clk),
        .reset      (reset),
        .call_req   (call_req),
        .serve      (serve),
        .eval_floor (eval_floor),
        .pending    (pending),
        .here       (here),
        .above      (above),
        .below      (below)
    );

    assign idle = (state == IDLE) && (pending == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            floor       <= '0;
            dir         <= UP;
            mcnt        <= '0;
            dcnt        <= '0;
            door_open   <= 1'b0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (here) begin
                        state     <= DOOR_OPEN;
                        door_open <= 1'b1;
                        dcnt      <= '0;
                    end else if (above && ((dir == UP) || !below)) begin
                        state     <= MOVE_UP;
                        moving_up <= 1'b1;
                        dir       <= UP;
                        mcnt      <= '0;
                    end else if (below) begin
                        state       <= MOVE_DOWN;
                        moving_down <= 1'b1;
                        dir         <= DOWN;
                        mcnt        <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (!step) begin
                        mcnt <= mcnt + MCNT_W'(1);
                    end else begin
                        floor <= eval_floor;
                        mcnt  <= '0;
                        if (here) begin
                            state       <= DOOR_OPEN;
                            door_open   <= 1'b1;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                            dcnt        <= '0;
                        end else if (!((state == MOVE_UP) ? above : below)) begin
                            state       <= IDLE;
                            moving_up   <= 1'b0;
                            moving_down <= 1'b0;
                        end
                    end
                end
                DOOR_OPEN: begin
                    // A fresh call at this floor holds the door open for a full dwell again.
                    if (call_req[floor]) begin
                        dcnt <= '0;
                    end else if (dcnt == DCNT_LAST) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                        dcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + DCNT_W'(1);
                    end
                end
                default: begin
                    state       <= IDLE;
                    door_open   <= 1'b0;
                    moving_up   <= 1'b0;
                    moving_down <= 1'b0;
                end
            endcase
        end
    end

endmodule
